// File: rtl/divclk_freq_meter.sv
// ---------------------------------------------------------------------------
// divclk_freq_meter
//
// Receive-side companion to the clock divider. It counts rising edges on up
// to NUM_CH looped-back divider outputs over a programmable gate window of
// wb_clk_i cycles. It then latches the per-channel counts into result
// registers, which are read back one channel at a time.
//
// Ports
//   wb_clk_i   system clock; every flop is on its rising edge
//   wb_rst_i   synchronous active-high reset
//   sig_in     asynchronous signals under measurement (bit k = channel k)
//   start      request a measurement; only sampled while idle
//   gate_len   gate window length in wb_clk_i cycles (0 behaves as 1)
//   ch_sel     selects the result channel shown on count_out/overflow
//   busy       high from the cycle after start is accepted until done
//   done       one-cycle pulse when new results have been latched
//   count_out  registered result count for ch_sel (0 if ch_sel >= NUM_CH)
//   overflow   registered saturation flag for ch_sel
// ---------------------------------------------------------------------------
module divclk_freq_meter #(
  parameter int NUM_CH = 10,
  parameter int CNT_W  = 16,
  parameter int GATE_W = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [NUM_CH-1:0] sig_in,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_len,
  input  logic [3:0]        ch_sel,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count_out,
  output logic              overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    GATE  = 2'd2,
    LATCH = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [4:0]        NUM_CH_L = 5'(NUM_CH);
  localparam logic [GATE_W-1:0] GATE_ONE = GATE_W'(1);

  state_t            state_q, state_d;
  logic [GATE_W-1:0] gate_cnt_q;
  logic              gate_last;
  logic              start_accept;

  logic [NUM_CH-1:0] sync1_q, sync2_q, sync3_q;
  logic [NUM_CH-1:0] rise;

  logic [CNT_W-1:0]  cnt_q     [NUM_CH];
  logic [NUM_CH-1:0] ovf_q;
  logic [CNT_W-1:0]  res_cnt_q [NUM_CH];
  logic [NUM_CH-1:0] res_ovf_q;

  logic              done_q;
  logic [CNT_W-1:0]  count_out_q;
  logic              overflow_q;

  // -------------------------------------------------------------------------
  // Input conditioning: two-flop synchronizer plus one flop for edge detect.
  // The two-cycle synchronizer latency is deliberately not compensated; a
  // periodic input still yields the right count over a whole gate window.
  // -------------------------------------------------------------------------
  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples the pre-edge value of its source, whatever the
  // statement order.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
    end else begin
      sync1_q <= sig_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign rise = sync2_q & ~sync3_q;

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  assign start_accept = (state_q == IDLE) && start;
  assign gate_last    = (gate_cnt_q == GATE_ONE);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every signal driven here gets a default before the case statement,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = ARM;
      ARM:     state_d = GATE;
      GATE:    if (gate_last) state_d = LATCH;
      LATCH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Gate counter: loaded on an accepted start, counts down through GATE.
  // The cycle it reads 1 is the last gate cycle, so GATE lasts gate_len
  // cycles. A zero length is promoted to 1 so the window never wraps.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      gate_cnt_q <= '0;
    end else if (start_accept) begin
      gate_cnt_q <= (gate_len == '0) ? GATE_ONE : gate_len;
    end else if (state_q == GATE) begin
      gate_cnt_q <= gate_cnt_q - GATE_ONE;
    end
  end

  // -------------------------------------------------------------------------
  // Per-channel saturating edge counters and working overflow flags.
  // -------------------------------------------------------------------------
  // NOTE: the counter and result arrays are explicitly reset. They are small
  // flop arrays, not RAM, and a reset must leave the read path showing zeros.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= '0;
      ovf_q <= '0;
    end else if (state_q == ARM) begin
      for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= '0;
      ovf_q <= '0;
    end else if (state_q == GATE) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (rise[k]) begin
          if (cnt_q[k] == CNT_MAX) begin
            ovf_q[k] <= 1'b1;
          end else begin
            cnt_q[k] <= cnt_q[k] + 1'b1;
          end
        end
      end
    end
  end

  // Result registers hold their value until the next LATCH; ARM leaves them
  // alone, so old results stay readable while a new measurement runs.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int k = 0; k < NUM_CH; k++) res_cnt_q[k] <= '0;
      res_ovf_q <= '0;
    end else if (state_q == LATCH) begin
      for (int k = 0; k < NUM_CH; k++) res_cnt_q[k] <= cnt_q[k];
      res_ovf_q <= ovf_q;
    end
  end

  // done fires in the cycle after LATCH, which is already IDLE, so busy is
  // low in that same cycle and a held start is accepted there.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == LATCH);
    end
  end

  // -------------------------------------------------------------------------
  // Registered read path; out-of-range selects read back as zero.
  // -------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      count_out_q <= '0;
      overflow_q  <= 1'b0;
    end else if ({1'b0, ch_sel} < NUM_CH_L) begin
      count_out_q <= res_cnt_q[ch_sel];
      overflow_q  <= res_ovf_q[ch_sel];
    end else begin
      count_out_q <= '0;
      overflow_q  <= 1'b0;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign count_out = count_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_divclk_freq_meter.sv
// ---------------------------------------------------------------------------
// tb_divclk_freq_meter
//
// Directed and randomized bench for divclk_freq_meter. Two instances share
// the same stimulus:
//   - a default one with 16-bit counters;
//   - a 3-bit-counter one for the saturation behaviour.
// Input signals are ideal periodic waveforms generated here. Expected counts
// come from the period/gate arithmetic (gate_len / P, clipped at the counter
// maximum), never from the DUT.
// ---------------------------------------------------------------------------
module tb_divclk_freq_meter;

  localparam int NUM_CH = 10;

  logic              clk;
  logic              rst;
  logic [NUM_CH-1:0] sig_in;
  logic              start;
  logic [15:0]       gate_len;
  logic [3:0]        ch_sel;

  logic              busy, done, overflow;
  logic [15:0]       count_out;
  logic              busy_s, done_s, ovf_s;
  logic [2:0]        count_s;

  int compared   = 0;
  int mismatched = 0;

  // Waveform description per channel: period 0 means "hold lvl".
  int per   [NUM_CH];
  bit lvl   [NUM_CH];
  int phase [NUM_CH];

  divclk_freq_meter #(.NUM_CH(NUM_CH), .CNT_W(16), .GATE_W(16)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .sig_in   (sig_in),
    .start    (start),
    .gate_len (gate_len),
    .ch_sel   (ch_sel),
    .busy     (busy),
    .done     (done),
    .count_out(count_out),
    .overflow (overflow)
  );

  divclk_freq_meter #(.NUM_CH(NUM_CH), .CNT_W(3), .GATE_W(16)) dut_small (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .sig_in   (sig_in),
    .start    (start),
    .gate_len (gate_len),
    .ch_sel   (ch_sel),
    .busy     (busy_s),
    .done     (done_s),
    .count_out(count_s),
    .overflow (ovf_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, then drive the next waveform sample.
  task automatic step();
    @(negedge clk);
    for (int k = 0; k < NUM_CH; k++) begin
      if (per[k] == 0) begin
        sig_in[k] = lvl[k];
      end else begin
        phase[k]  = (phase[k] + 1) % per[k];
        sig_in[k] = (phase[k] < per[k] / 2);
      end
    end
  endtask

  // Launch one measurement; lat = cycles from the start cycle to done.
  task automatic measure(input int g, output int lat);
    gate_len = 16'(g);
    start    = 1'b1;
    lat      = -1;
    for (int n = 1; n <= 300; n++) begin
      step();
      start = 1'b0;
      if (done) begin
        lat = n;
        break;
      end
    end
    check("done_busy_low", 32'(busy), 32'd0);
  endtask

  // Read one channel on both instances and compare with n expected edges.
  task automatic check_ch(input int ch, input int n);
    int exp_s;
    exp_s  = (n > 7) ? 7 : n;
    ch_sel = 4'(ch);
    step();
    check($sformatf("cnt[%0d]", ch),   32'(count_out), 32'(n));
    check($sformatf("ovf[%0d]", ch),   32'(overflow),  32'd0);
    check($sformatf("cnt_s[%0d]", ch), 32'(count_s),   32'(exp_s));
    check($sformatf("ovf_s[%0d]", ch), 32'(ovf_s),     32'(n > 7));
  endtask

  initial begin
    int lat, dones, first_done, second_done, changes, g;
    int choices [5] = '{0, 2, 3, 4, 6};

    rst = 1'b1; start = 1'b0; gate_len = '0; ch_sel = '0; sig_in = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      per[k] = 0; lvl[k] = 1'b0; phase[k] = 0;
    end

    // 1. Reset values for every select value.
    repeat (3) step();
    rst = 1'b0;
    for (int c = 0; c < 16; c++) begin
      ch_sel = 4'(c);
      step();
      check("rst_busy",  32'(busy),      32'd0);
      check("rst_done",  32'(done),      32'd0);
      check($sformatf("rst_cnt[%0d]", c), 32'(count_out), 32'd0);
      check($sformatf("rst_ovf[%0d]", c), 32'(overflow),  32'd0);
    end

    // 2/3. Basic count; the 3-bit instance saturates on channel 0.
    per[0] = 2; per[1] = 4; per[2] = 0; lvl[2] = 1'b1;
    repeat (8) step();
    measure(16, lat);
    check("basic_latency", 32'(lat), 32'd19);
    check_ch(0, 8);
    check_ch(1, 4);
    check_ch(2, 0);
    ch_sel = 4'd12;
    step();
    check("sel12_cnt", 32'(count_out), 32'd0);
    check("sel12_ovf", 32'(overflow),  32'd0);
    measure(8, lat);
    check("g8_latency", 32'(lat), 32'd11);
    check_ch(0, 4);
    check_ch(1, 2);

    // Gate length 0 behaves as a one-cycle window.
    measure(0, lat);
    check("g0_latency", 32'(lat), 32'd4);
    check_ch(2, 0);

    // 4. A second start during GATE is ignored.
    gate_len = 16'd16;
    start = 1'b1;
    dones = 0; first_done = -1;
    for (int n = 1; n <= 60; n++) begin
      step();
      start = (n == 7);
      if (done) begin
        dones++;
        if (first_done < 0) first_done = n;
      end
    end
    check("busy_done_count", 32'(dones), 32'd1);
    check("busy_latency", 32'(first_done), 32'd19);
    check_ch(0, 8);
    check_ch(1, 4);

    // 5. Reset five cycles into GATE.
    gate_len = 16'd16;
    start = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      step();
      start = 1'b0;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    dones = 0;
    for (int n = 0; n < 25; n++) begin
      step();
      if (done) dones++;
    end
    check("midrst_no_done", 32'(dones), 32'd0);
    check_ch(0, 0);
    measure(16, lat);
    check("postrst_latency", 32'(lat), 32'd19);
    check_ch(0, 8);
    check_ch(1, 4);

    // 6. Back-to-back with start held; channel 0 goes from period 2 to 4.
    ch_sel = 4'd0;
    gate_len = 16'd16;
    start = 1'b1;
    first_done = -1; second_done = -1; changes = 0;
    for (int n = 1; n <= 45; n++) begin
      step();
      if (n == 16) begin
        per[0] = 4; phase[0] = 0;
      end
      if (done) begin
        if (first_done < 0) first_done = n;
        else if (second_done < 0) second_done = n;
      end
      if (n >= 20 && n <= 38 && count_out !== 16'd8) changes++;
      if (n == 39) check("b2b_second_result", 32'(count_out), 32'd4);
    end
    start = 1'b0;
    check("b2b_first_done", 32'(first_done), 32'd19);
    check("b2b_spacing", 32'(second_done - first_done), 32'd19);
    check("b2b_hold_between", 32'(changes), 32'd0);
    repeat (30) step();

    // Randomized measurements against the period/gate model.
    for (int it = 0; it < 6; it++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        per[k]   = choices[$urandom_range(0, 4)];
        lvl[k]   = 1'($urandom_range(0, 1));
        phase[k] = $urandom_range(0, 5);
      end
      repeat (8) step();
      g = 12 * $urandom_range(1, 6);
      measure(g, lat);
      check($sformatf("rnd%0d_latency", it), 32'(lat), 32'(g + 3));
      for (int k = 0; k < NUM_CH; k++) begin
        check_ch(k, (per[k] == 0) ? 0 : g / per[k]);
      end
      ch_sel = 4'($urandom_range(10, 15));
      step();
      check($sformatf("rnd%0d_oob_cnt", it), 32'(count_out), 32'd0);
      check($sformatf("rnd%0d_oob_ovf", it), 32'(overflow),  32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/divclk_freq_meter.md
Name: divclk_freq_meter

Overview:
Receive-side companion to the clock divider.
- Measures up to NUM_CH divided-clock signals looped back through io_in.
- Counts rising edges of each input over a programmable gate window of wb_clk_i cycles.
- Latches the per-channel counts into result registers, read one channel at a time through ch_sel.
- Sits in user_project_wrapper beside the divider and gives self-test or characterisation of the divider outputs.

Parameters:
NUM_CH, 10, number of measured input channels (1..16)
CNT_W, 16, width of each edge counter and result register
GATE_W, 16, width of the gate_len input

Ports:
wb_clk_i  input  1  system clock; every flop is on its rising edge
wb_rst_i  input  1  synchronous active-high reset
sig_in  input  NUM_CH  asynchronous signals under measurement (bit k = channel k)
start  input  1  request a measurement; sampled only in IDLE
gate_len  input  GATE_W  gate window length in wb_clk_i cycles; sampled on accepted start
ch_sel  input  4  selects the result channel shown on count_out/overflow
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse when new results are latched
count_out  output  CNT_W  registered result for ch_sel
overflow  output  1  registered saturation flag for ch_sel

Behaviour:
- Reset (wb_rst_i=1 at a clock edge). Applies from any state, including mid-GATE:
  - FSM goes to IDLE.
  - busy=0, done=0, count_out=0, overflow=0.
  - All counters, result registers, overflow flags, synchronizer and edge flops are cleared.
- Input conditioning, per channel:
  - Two-flop synchronizer, then a third flop for edge detection.
  - rise_k = s2 & ~s3.
  - Synchronizer latency is not compensated.
- FSM states: IDLE, ARM, GATE, LATCH.
  - IDLE: when start=1, capture gate_len into gate_cnt and go to ARM. busy rises in the next cycle.
  - IDLE with gate_len=0 on start: treated as 1.
  - ARM: one cycle. Clear all edge counters and working overflow flags. Go to GATE.
  - GATE: lasts exactly gate_len cycles.
    - Each cycle, every channel with rise_k=1 increments its counter.
    - gate_cnt decrements each cycle. Go to LATCH on the cycle gate_cnt reaches 1.
  - LATCH: one cycle. Copy counters and overflow flags into the result registers. Go to IDLE.
    - done=1 and busy=0 in the cycle after LATCH.
- Saturation: a counter at 2^CNT_W-1 that sees another rise holds its value and sets its overflow flag. The flag stays set until the next ARM.
- start while busy (ARM/GATE/LATCH): ignored, with no queuing.
- start=1 held continuously: back-to-back measurements. A new start is accepted in the IDLE cycle after done.
- Result registers keep their previous values until the next LATCH. They are not cleared at ARM.
- Read path:
  - count_out and overflow are registered from result[ch_sel], so they follow ch_sel changes with 1 cycle of latency.
  - ch_sel >= NUM_CH gives count_out=0, overflow=0.
- A signal of period P cycles (P>=2, synchronous to the bench) gives exactly gate_len/P edges when gate_len is a multiple of P.
- Signals faster than wb_clk_i/2 are out of spec and give undefined counts.

Test Plan:
1. Reset value: hold wb_rst_i for 3 cycles and release -> busy=0, done=0, count_out=0, overflow=0 for every ch_sel 0..15.
2. Basic count: gate_len=16, sig_in[0] period 2, sig_in[1] period 4, sig_in[2] held 1, pulse start.
   - done pulses exactly 19 cycles after the start cycle (ARM 1 + GATE 16 + LATCH 1 + 1).
   - ch_sel=0 -> 8, ch_sel=1 -> 4, ch_sel=2 -> 0, all with overflow=0.
   - ch_sel=12 -> 0.
3. Saturation with CNT_W=3: sig_in[0] period 2, gate_len=16 -> count_out=7, overflow=1.
   - Then gate_len=8 -> count_out=4, overflow=0.
4. Busy protocol: pulse start again during GATE -> ignored, only one done pulse. Results match a single measurement.
5. Reset mid-GATE: assert wb_rst_i 5 cycles into GATE -> FSM in IDLE, results 0, no done. A following start measures correctly.
6. Back-to-back measurements:
   - Hold start=1, first gate period 2 then switch sig_in[0] to period 4 -> successive done pulses 19 cycles apart, results 8 then 4.
   - Results are unchanged between done pulses.
